// File: rtl/tlb_sa.sv
// Set-associative TLB: VA+PCID -> PA with one registered lookup cycle, fill port with
// round-robin replacement (invalid way first), and a one-set-per-cycle invalidation sweep.
module tlb_sa #(
   parameter int VA_W       = 64,
   parameter int PA_W       = 64,
   parameter int PCID_W     = 12,
   parameter int PAGE_SHIFT = 12,
   parameter int SETS       = 4,
   parameter int WAYS       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lk_valid,
   output logic              lk_ready,
   input  logic [VA_W-1:0]   lk_va,
   input  logic [PCID_W-1:0] lk_pcid,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic [PA_W-1:0]   rsp_pa,
   output logic [WAYS-1:0]   rsp_way,
   input  logic              fill_valid,
   output logic              fill_ready,
   input  logic [VA_W-1:0]   fill_va,
   input  logic [PCID_W-1:0] fill_pcid,
   input  logic [PA_W-1:0]   fill_pa,
   input  logic              inv_valid,
   input  logic              inv_all,
   input  logic [PCID_W-1:0] inv_pcid,
   output logic              inv_ready,
   output logic              busy
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int TAG_W = VA_W - PAGE_SHIFT - IDX_W;
   localparam int PPN_W = PA_W - PAGE_SHIFT;

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   state_t              r_state, w_next;
   logic [IDX_W-1:0]    r_cnt;
   logic                r_inv_all;
   logic [PCID_W-1:0]   r_inv_pcid;
   logic [WAYS-1:0]     r_vld  [SETS];
   logic [WAY_W-1:0]    r_rr   [SETS];
   logic [TAG_W-1:0]    r_tag  [SETS][WAYS];
   logic [PCID_W-1:0]   r_pcid [SETS][WAYS];
   logic [PPN_W-1:0]    r_ppn  [SETS][WAYS];
   logic                r_rsp_vld, r_rsp_hit;
   logic [PA_W-1:0]     r_rsp_pa;
   logic [WAYS-1:0]     r_rsp_way;

   logic                w_lk_acc, w_fill_acc, w_inv_acc;
   logic [IDX_W-1:0]    w_lk_idx, w_f_idx;
   logic [TAG_W-1:0]    w_lk_tag, w_f_tag;
   logic [WAYS-1:0]     w_lk_hit;
   logic [PPN_W-1:0]    w_lk_ppn;
   logic                w_f_match, w_f_found, w_f_evict;
   logic [WAY_W-1:0]    w_f_match_way, w_f_inv_way, w_f_way;
   logic                w_unused;

   assign w_lk_idx   = lk_va[PAGE_SHIFT +: IDX_W];
   assign w_lk_tag   = lk_va[VA_W-1:PAGE_SHIFT+IDX_W];
   assign w_f_idx    = fill_va[PAGE_SHIFT +: IDX_W];
   assign w_f_tag    = fill_va[VA_W-1:PAGE_SHIFT+IDX_W];
   assign w_lk_acc   = lk_valid & lk_ready;
   assign w_fill_acc = fill_valid & fill_ready;
   assign w_inv_acc  = inv_valid & inv_ready;
   assign w_unused   = ^{fill_va[PAGE_SHIFT-1:0], fill_pa[PAGE_SHIFT-1:0]};

   assign rsp_valid = r_rsp_vld;
   assign rsp_hit   = r_rsp_hit;
   assign rsp_pa    = r_rsp_pa;
   assign rsp_way   = r_rsp_way;

   always_comb begin
      w_next     = r_state;
      lk_ready   = 1'b0;
      fill_ready = 1'b0;
      inv_ready  = 1'b0;
      busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            lk_ready   = 1'b1;
            fill_ready = 1'b1;
            inv_ready  = 1'b1;
            if (inv_valid) w_next = S_SWEEP;
         end
         S_SWEEP: begin
            busy = 1'b1;
            if (r_cnt == IDX_W'(SETS-1)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_lk_hit = '0;
      w_lk_ppn = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_lk_hit[w] = r_vld[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag) &&
                       (r_pcid[w_lk_idx][w] == lk_pcid);
         if (w_lk_hit[w]) w_lk_ppn = w_lk_ppn | r_ppn[w_lk_idx][w];
      end
   end

   // Descending scan so the lowest-index invalid way is the one left selected.
   always_comb begin
      w_f_match     = 1'b0;
      w_f_found     = 1'b0;
      w_f_match_way = '0;
      w_f_inv_way   = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (!r_vld[w_f_idx][w]) begin
            w_f_found   = 1'b1;
            w_f_inv_way = WAY_W'(w);
         end
         if (r_vld[w_f_idx][w] && (r_tag[w_f_idx][w] == w_f_tag) &&
             (r_pcid[w_f_idx][w] == fill_pcid)) begin
            w_f_match     = 1'b1;
            w_f_match_way = WAY_W'(w);
         end
      end
      w_f_evict = !w_f_match && !w_f_found;
      w_f_way   = w_f_match ? w_f_match_way : (w_f_found ? w_f_inv_way : r_rr[w_f_idx]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_inv_all  <= 1'b0;
         r_inv_pcid <= '0;
         r_rsp_vld  <= 1'b0;
         r_rsp_hit  <= 1'b0;
         r_rsp_pa   <= '0;
         r_rsp_way  <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_vld[s] <= '0;
            r_rr[s]  <= '0;
         end
      end else begin
         r_state   <= w_next;
         r_rsp_vld <= w_lk_acc;
         r_rsp_hit <= w_lk_acc && (|w_lk_hit);
         r_rsp_way <= w_lk_acc ? w_lk_hit : '0;
         r_rsp_pa  <= (w_lk_acc && (|w_lk_hit)) ? {w_lk_ppn, lk_va[PAGE_SHIFT-1:0]} : '0;
         if (w_fill_acc) begin
            r_vld[w_f_idx][w_f_way] <= 1'b1;
            if (w_f_evict) r_rr[w_f_idx] <= r_rr[w_f_idx] + WAY_W'(1);
         end
         if (w_inv_acc) begin
            r_cnt      <= '0;
            r_inv_all  <= inv_all;
            r_inv_pcid <= inv_pcid;
         end
         if (r_state == S_SWEEP) begin
            r_cnt <= r_cnt + IDX_W'(1);
            for (int w = 0; w < WAYS; w++)
               if (r_inv_all || (r_pcid[r_cnt][w] == r_inv_pcid)) r_vld[r_cnt][w] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_acc) begin
         r_tag[w_f_idx][w_f_way]  <= w_f_tag;
         r_pcid[w_f_idx][w_f_way] <= fill_pcid;
         r_ppn[w_f_idx][w_f_way]  <= fill_pa[PA_W-1:PAGE_SHIFT];
      end
   end
endmodule
